// File: rtl/ring_token_pass.sv
// Active side of the ring protocol: circulates one token over K stations,
// retransmitting after a timeout when the channel drops it.
module ring_token_pass #(
    parameter int K        = 8,
    parameter int LAT      = 2,
    parameter int TIMEOUT  = 4,
    parameter int MAX_RETX = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic       loss,
    output logic       send,
    output logic [5:0] holder,
    output logic       hop,
    output logic       retx,
    output logic       round_done,
    output logic       stable,
    output logic       fail
);

    // state | meaning
    // INIT  | single cycle after reset release
    // SEND  | token ready; sends this cycle unless hold
    // WAIT  | token in flight; timer runs to delivery or timeout
    // FAIL  | too many consecutive retransmissions; terminal until reset
    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_FAIL = 2'd3;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (MAX_RETX < 2) ? 1 : $clog2(MAX_RETX + 1);

    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic          lost;
    logic [RW-1:0] retry_cnt;
    logic [6:0]    clean_cnt;

    logic          wrap;
    logic [5:0]    holder_nxt;
    logic [RW-1:0] retry_nxt;
    logic [6:0]    clean_nxt;

    assign send       = (state == ST_SEND) && !hold;
    assign wrap       = (holder == 6'(K - 1));
    assign holder_nxt = wrap ? 6'd0 : holder + 6'd1;
    assign retry_nxt  = retry_cnt + RW'(1);
    assign clean_nxt  = (clean_cnt == 7'(K)) ? clean_cnt : clean_cnt + 7'd1;

    // The timer is loaded with the full wait (LAT or TIMEOUT, chosen by the
    // captured loss) and counts down; terminal count 1 marks the last cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_INIT;
            holder     <= 6'd0;
            hop        <= 1'b0;
            retx       <= 1'b0;
            round_done <= 1'b0;
            stable     <= 1'b0;
            fail       <= 1'b0;
            timer      <= '0;
            lost       <= 1'b0;
            retry_cnt  <= '0;
            clean_cnt  <= 7'd0;
        end else begin
            hop        <= 1'b0;
            retx       <= 1'b0;
            round_done <= 1'b0;
            case (state)
                ST_INIT: state <= ST_SEND;
                ST_SEND: begin
                    if (!hold) begin
                        lost  <= loss;
                        timer <= loss ? TW'(TIMEOUT) : TW'(LAT);
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (timer == TW'(1)) begin
                        timer <= '0;
                        if (!lost) begin
                            holder     <= holder_nxt;
                            hop        <= 1'b1;
                            round_done <= wrap;
                            retry_cnt  <= '0;
                            clean_cnt  <= clean_nxt;
                            if (clean_nxt == 7'(K))
                                stable <= 1'b1;
                            state <= ST_SEND;
                        end else begin
                            retx      <= 1'b1;
                            clean_cnt <= 7'd0;
                            stable    <= 1'b0;
                            retry_cnt <= retry_nxt;
                            if (retry_nxt == RW'(MAX_RETX)) begin
                                fail  <= 1'b1;
                                state <= ST_FAIL;
                            end else begin
                                state <= ST_SEND;
                            end
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ST_FAIL: state <= ST_FAIL;
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_token_pass.sv
// Randomized bench for ring_token_pass against a deadline-based token model,
// plus hand-computed timeline checks for the directed scenarios.
module tb_ring_token_pass;

    localparam int K        = 8;
    localparam int LAT      = 2;
    localparam int TIMEOUT  = 4;
    localparam int MAX_RETX = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hold = 1'b0;
    logic       loss = 1'b0;
    logic       send;
    logic [5:0] holder;
    logic       hop, retx, round_done, stable, fail;

    ring_token_pass #(.K(K), .LAT(LAT), .TIMEOUT(TIMEOUT), .MAX_RETX(MAX_RETX)) dut (
        .clk(clk), .reset(reset), .hold(hold), .loss(loss), .send(send),
        .holder(holder), .hop(hop), .retx(retx), .round_done(round_done),
        .stable(stable), .fail(fail)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Model: phase 0 = just out of reset, 1 = token ready, 2 = in flight, 3 = dead.
    int m_phase, m_due, m_holder, m_retries, m_clean;
    bit m_lost, m_hop, m_retx, m_rd, m_stable, m_fail;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_due = 0; m_holder = 0; m_retries = 0; m_clean = 0;
        m_lost = 0; m_hop = 0; m_retx = 0; m_rd = 0; m_stable = 0; m_fail = 0;
    endtask

    task automatic model_step(input bit h, input bit l);
        m_hop = 0; m_retx = 0; m_rd = 0;
        case (m_phase)
            0: m_phase = 1;
            1: if (!h) begin
                   m_lost  = l;
                   m_due   = cyc + (l ? TIMEOUT : LAT);
                   m_phase = 2;
               end
            2: if (cyc == m_due) begin
                   if (!m_lost) begin
                       m_rd      = (m_holder == K - 1);
                       m_holder  = (m_holder + 1) % K;
                       m_hop     = 1;
                       m_retries = 0;
                       if (m_clean < K) m_clean++;
                       if (m_clean == K) m_stable = 1;
                       m_phase = 1;
                   end else begin
                       m_retx    = 1;
                       m_clean   = 0;
                       m_stable  = 0;
                       m_retries++;
                       if (m_retries == MAX_RETX) begin
                           m_fail  = 1;
                           m_phase = 3;
                       end else begin
                           m_phase = 1;
                       end
                   end
               end
            default: ;
        endcase
    endtask

    task automatic compare_all(input bit h);
        check("send",       int'(send),       int'(m_phase == 1 && !h));
        check("holder",     int'(holder),     m_holder);
        check("hop",        int'(hop),        int'(m_hop));
        check("retx",       int'(retx),       int'(m_retx));
        check("round_done", int'(round_done), int'(m_rd));
        check("stable",     int'(stable),     int'(m_stable));
        check("fail",       int'(fail),       int'(m_fail));
    endtask

    // Each iteration starts on a falling edge: drive, sample, advance model.
    task automatic run_cycles(input int n, input int hold_pct, input int loss_pct, input int loss_at);
        bit h, l;
        for (int i = 0; i < n; i++) begin
            h = (hold_pct > 0) && ($urandom_range(99) < hold_pct);
            l = (loss_pct > 0) && ($urandom_range(99) < loss_pct);
            if (cyc == loss_at) l = 1'b1;
            hold = h;
            loss = l;
            #1;
            compare_all(h);
            model_step(h, l);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        hold  = 1'b0;
        loss  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        model_reset();

        // Clean circulation: first send in cycle 1, hop every 3 cycles.
        do_reset();
        run_cycles(4, 0, 0, -1);
        #1;
        check("lit_first_hop", int'(hop), 1);
        check("lit_first_holder", int'(holder), 1);
        run_cycles(20, 0, 0, -1);
        #1;
        check("lit_holder7", int'(holder), 7);
        check("lit_stable_before", int'(stable), 0);
        run_cycles(1, 0, 0, -1);
        #1;
        check("lit_wrap_holder", int'(holder), 0);
        check("lit_round_done", int'(round_done), 1);
        check("lit_stable_8th", int'(stable), 1);

        // Single loss on the third send (cycle 7, holder 2).
        do_reset();
        run_cycles(12, 0, 0, 7);
        #1;
        check("lit_retx_pulse", int'(retx), 1);
        check("lit_retx_holder", int'(holder), 2);
        run_cycles(3, 0, 0, -1);
        #1;
        check("lit_resend_holder", int'(holder), 3);
        run_cycles(20, 0, 0, -1);
        #1;
        check("lit_stable_35", int'(stable), 0);
        run_cycles(1, 0, 0, -1);
        #1;
        check("lit_stable_36", int'(stable), 1);

        // Loss after stable: send in cycle 28 lost, retx in cycle 33.
        do_reset();
        run_cycles(33, 0, 0, 28);
        #1;
        check("lit_stable_loss_retx", int'(retx), 1);
        check("lit_stable_loss_drop", int'(stable), 0);
        run_cycles(10, 0, 0, -1);

        // Every send lost: retx in cycles 6, 11, 16; FAIL from the third.
        do_reset();
        run_cycles(15, 0, 100, -1);
        #1;
        check("lit_fail_before", int'(fail), 0);
        run_cycles(1, 0, 100, -1);
        #1;
        check("lit_fail_retx", int'(retx), 1);
        check("lit_fail_set", int'(fail), 1);
        run_cycles(10, 0, 100, -1);
        #1;
        check("lit_fail_send", int'(send), 0);
        check("lit_fail_holder", int'(holder), 0);

        // Hold through cycles 0..10, release: send in 11, hop in 14.
        do_reset();
        run_cycles(11, 100, 0, -1);
        run_cycles(3, 0, 0, -1);
        #1;
        check("lit_hold_hop", int'(hop), 1);
        check("lit_hold_holder", int'(holder), 1);
        run_cycles(30, 60, 0, -1);

        // Async reset in the first WAIT cycle after the send in cycle 4.
        do_reset();
        run_cycles(5, 0, 0, -1);
        reset = 1'b1;
        #1;
        check("lit_async_holder", int'(holder), 0);
        check("lit_async_send", int'(send), 0);
        check("lit_async_hop", int'(hop), 0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        run_cycles(4, 0, 0, -1);
        #1;
        check("lit_async_resume", int'(holder), 1);
        run_cycles(10, 0, 0, -1);

        // Randomized hold/loss mixes.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            run_cycles(300, (r * 15) % 70, (r % 3) * 8 + 2, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
